pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the nibble processor core, the successor to the fixed 12-bit load/increment PC. Generates the fetch/execute phase and next instruction address, and adds skip, relative branch and a hardware call/return stack with sticky overflow/underflow flags. Sits between the control decoder, which supplies `op`/`target`, and the program-memory address bus.

## Interface
Parameters:
- `ADDR_W`, 12, address width in bits (≥4)
- `STACK_DEPTH`, 4, return-stack entries (≥1)
- `RESET_ADDR`, 0, address loaded on reset

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset
- `run`  in  1  1 = sequencer advances; 0 = freeze phase, addr, stack
- `op`  in  3  next-address operation, sampled in execute phase
- `target`  in  ADDR_W  absolute address (JMP/CALL) or two's-complement offset (BRA)
- `err_clr`  in  1  clears `ovf`/`unf`
- `addr`  out  ADDR_W  current instruction address
- `phase`  out  1  1 = fetch, 0 = execute
- `depth`  out  $clog2(STACK_DEPTH+1)  valid stack entries
- `ovf`  out  1  sticky: CALL issued with stack full
- `unf`  out  1  sticky: RET issued with stack empty

## Operation
- Reset (`reset`=0 at edge): `addr`=RESET_ADDR, `phase`=1, `depth`=0, `ovf`=0, `unf`=0; stack contents don't-care. Reset overrides `run`, `op`, `err_clr`.
- `run`=1: `phase` toggles every cycle. `run`=0: all state holds; `op` ignored.
- Address/stack update only at an edge where `run`=1 and `phase`=0 (end of execute). All arithmetic is modulo 2^ADDR_W.
- `op` encoding:
  - 000 INC: addr+1
  - 001 SKIP: addr+2
  - 010 JMP: target
  - 011 BRA: addr + signed(target)
  - 100 CALL: push addr+1, addr ← target
  - 101 RET: addr ← top, pop
  - 110 HOLD: addr unchanged
  - 111 reserved: behaves as INC
- Stack is LIFO. Full CALL (`depth`=STACK_DEPTH): oldest entry discarded, new return address pushed, `depth` unchanged, jump taken, `ovf` ← 1.
- Empty RET (`depth`=0): addr ← addr+1, `depth` stays 0, `unf` ← 1.
- `err_clr`=1 clears both flags at any edge (phase and `run` irrelevant). If a new ovf/unf event occurs on the same edge, set wins.

## Timing
- `op`/`target` must be stable at the rising edge that ends the execute cycle; the new `addr` is visible in the following fetch cycle (1-cycle latency from sampling edge).
- `addr` is constant across each fetch/execute pair; changes only coincident with `phase` 0→1.
- After reset release: first edge with `run`=1 sets `phase`=0 and holds `addr`=RESET_ADDR; the second edge applies `op`.
- `depth`, `ovf`, `unf` update on the same edge as `addr`. `err_clr` takes effect on the next edge.
- `run` deasserted mid-pair: phase freezes; resuming continues the same pair with no lost or repeated update.
- Reset mid-pair or mid-call chain: returns to reset values on that edge; stack is emptied.

## Test plan
- Reset, `run`=1, `op`=INC for 8 cycles → `phase` 1,0,1,0…; `addr` 0,0,1,1,2,2,3,3.
- ADDR_W=12: JMP 0xFFE, then SKIP → 0x000 (wrap); BRA with `target`=0xFFD from 0x010 → 0x00D.
- CALL 0x100 from 0x020, CALL 0x200, RET, RET → addr 0x100, 0x200, 0x101, 0x021; `depth` 1,2,1,0.
- STACK_DEPTH=4: five nested CALLs → `depth`=4, `ovf`=1; five RETs → last four return addresses in LIFO order, fifth RET gives addr+1 and `unf`=1.
- `err_clr` asserted on the same edge as an overflowing CALL → `ovf`=1; assert alone next → `ovf`=0, `unf`=0.
- `run`=0 for 3 cycles in execute phase with `op` changing → `addr`, `phase`, `depth` unchanged; reset asserted with `depth`=3 → `addr`=RESET_ADDR, `depth`=0, `phase`=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch/execute phase, next-address generation,
// and a hardware call/return stack with sticky overflow/underflow flags.
module pc_sequencer #(
   parameter int                  ADDR_W      = 12,
   parameter int                  STACK_DEPTH = 4,
   parameter logic [ADDR_W-1:0]   RESET_ADDR  = '0,
   localparam int                 DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic [2:0]         op,
   input  logic [ADDR_W-1:0]  target,
   input  logic               err_clr,
   output logic [ADDR_W-1:0]  addr,
   output logic               phase,
   output logic [DEPTH_W-1:0] depth,
   output logic               ovf,
   output logic               unf
);

   typedef enum logic [2:0] {
      OP_INC  = 3'b000,
      OP_SKIP = 3'b001,
      OP_JMP  = 3'b010,
      OP_BRA  = 3'b011,
      OP_CALL = 3'b100,
      OP_RET  = 3'b101,
      OP_HOLD = 3'b110,
      OP_RSVD = 3'b111
   } op_e;

   logic [ADDR_W-1:0]  addr_q,  addr_d;
   logic               phase_q, phase_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic               ovf_q,   ovf_d;
   logic               unf_q,   unf_d;
   // Entry 0 is the top of stack; a push shifts toward the end, dropping the oldest.
   logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
   logic [ADDR_W-1:0]  stack_d [STACK_DEPTH];

   logic stack_full, stack_empty;
   assign stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
   assign stack_empty = (depth_q == '0);

   // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      addr_d  = addr_q;
      phase_d = phase_q;
      depth_d = depth_q;
      stack_d = stack_q;
      ovf_d   = err_clr ? 1'b0 : ovf_q;
      unf_d   = err_clr ? 1'b0 : unf_q;

      if (run) begin
         phase_d = ~phase_q;
         if (!phase_q) begin
            case (op_e'(op))
               OP_SKIP: addr_d = addr_q + ADDR_W'(2);
               OP_JMP:  addr_d = target;
               OP_BRA:  addr_d = addr_q + target;
               OP_CALL: begin
                  stack_d[0] = addr_q + ADDR_W'(1);
                  for (int i = 1; i < STACK_DEPTH; i++) stack_d[i] = stack_q[i-1];
                  addr_d = target;
                  if (stack_full) ovf_d   = 1'b1;
                  else            depth_d = depth_q + DEPTH_W'(1);
               end
               OP_RET: begin
                  if (stack_empty) begin
                     addr_d = addr_q + ADDR_W'(1);
                     unf_d  = 1'b1;
                  end else begin
                     addr_d = stack_q[0];
                     for (int i = 0; i < STACK_DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
                     depth_d = depth_q - DEPTH_W'(1);
                  end
               end
               OP_HOLD: addr_d = addr_q;
               default: addr_d = addr_q + ADDR_W'(1);
            endcase
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!reset) begin
         addr_q  <= RESET_ADDR;
         phase_q <= 1'b1;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         phase_q <= phase_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // NOTE: stack storage is not reset; depth_q == 0 already marks it empty.
   always_ff @(posedge clk) begin
      stack_q <= stack_d;
   end

   assign addr  = addr_q;
   assign phase = phase_q;
   assign depth = depth_q;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected states are queued as each
// instruction pair is driven and popped when the pair completes.
module tb_pc_sequencer;

   localparam int ADDR_W      = 12;
   localparam int STACK_DEPTH = 4;
   localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1);

   localparam logic [2:0] INC = 3'b000, SKIP = 3'b001, JMP = 3'b010, BRA = 3'b011,
                          CALL = 3'b100, RET = 3'b101, HOLD = 3'b110, RSVD = 3'b111;

   typedef struct {
      logic [ADDR_W-1:0]  addr;
      logic               phase;
      logic [DEPTH_W-1:0] depth;
      logic               ovf;
      logic               unf;
   } exp_t;

   typedef struct {
      logic [2:0]        op;
      logic [ADDR_W-1:0] tgt;
      logic              clr;
      exp_t              e;
   } step_t;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               run = 1'b0;
   logic [2:0]         op = INC;
   logic [ADDR_W-1:0]  target = '0;
   logic               err_clr = 1'b0;
   logic [ADDR_W-1:0]  addr;
   logic               phase;
   logic [DEPTH_W-1:0] depth;
   logic               ovf;
   logic               unf;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   pc_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH), .RESET_ADDR('0)) dut (
      .clk(clk), .reset(reset), .run(run), .op(op), .target(target),
      .err_clr(err_clr), .addr(addr), .phase(phase), .depth(depth),
      .ovf(ovf), .unf(unf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One fetch/execute pair starting in fetch; the expected end state is queued.
   task automatic do_pair(input step_t s);
      run = 1'b1;
      err_clr = 1'b0;
      tick();
      op = s.op;
      target = s.tgt;
      err_clr = s.clr;
      sb.push_back(s.e);
      tick();
      err_clr = 1'b0;
      op = INC;
   endtask

   function automatic step_t st(logic [2:0] o, int t, logic c, int a, int d, logic ov, logic un);
      st.op = o;
      st.tgt = ADDR_W'(t);
      st.clr = c;
      st.e.addr = ADDR_W'(a);
      st.e.phase = 1'b1;
      st.e.depth = DEPTH_W'(d);
      st.e.ovf = ov;
      st.e.unf = un;
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      run = 1'b1;
      op = CALL;
      tick();
      tick();
      reset = 1'b1;
      run = 1'b0;
      checks++;
      if ({addr, phase, depth, ovf, unf} !== {ADDR_W'(0), 1'b1, DEPTH_W'(0), 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset: got addr=%h ph=%b d=%0d ovf=%b unf=%b, expected addr=000 ph=1 d=0 ovf=0 unf=0",
                  addr, phase, depth, ovf, unf);
      end
   endtask

   task automatic test_inc_phase();
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         e.addr = ADDR_W'(i / 2);
         e.phase = (i % 2 == 0);
         e.depth = '0;
         e.ovf = 1'b0;
         e.unf = 1'b0;
         sb.push_back(e);
      end
      run = 1'b1;
      op = INC;
      for (int i = 0; i < 8; i++) begin
         e = sb.pop_front();
         checks++;
         if (addr !== e.addr || phase !== e.phase) begin
            errors++;
            $display("FAIL inc_phase cycle %0d: got addr=%h ph=%b, expected addr=%h ph=%b",
                     i, addr, phase, e.addr, e.phase);
         end
         tick();
      end
   endtask

   task automatic test_wrap_bra();
      step_t s[4];
      exp_t  e;
      s[0] = st(JMP,  'hFFE, 0, 'hFFE, 0, 0, 0);
      s[1] = st(SKIP, 'h000, 0, 'h000, 0, 0, 0);
      s[2] = st(JMP,  'h010, 0, 'h010, 0, 0, 0);
      s[3] = st(BRA,  'hFFD, 0, 'h00D, 0, 0, 0);
      foreach (s[i]) begin
         do_pair(s[i]);
         e = sb.pop_front();
         checks++;
         if ({addr, phase, depth, ovf, unf} !== {e.addr, e.phase, e.depth, e.ovf, e.unf}) begin
            errors++;
            $display("FAIL wrap_bra step %0d: got addr=%h ph=%b d=%0d ovf=%b unf=%b, expected addr=%h ph=%b d=%0d ovf=%b unf=%b",
                     i, addr, phase, depth, ovf, unf, e.addr, e.phase, e.depth, e.ovf, e.unf);
         end
      end
   endtask

   task automatic test_call_ret();
      step_t s[5];
      exp_t  e;
      s[0] = st(JMP,  'h020, 0, 'h020, 0, 0, 0);
      s[1] = st(CALL, 'h100, 0, 'h100, 1, 0, 0);
      s[2] = st(CALL, 'h200, 0, 'h200, 2, 0, 0);
      s[3] = st(RET,  'h000, 0, 'h101, 1, 0, 0);
      s[4] = st(RET,  'h000, 0, 'h021, 0, 0, 0);
      foreach (s[i]) begin
         do_pair(s[i]);
         e = sb.pop_front();
         checks++;
         if ({addr, phase, depth, ovf, unf} !== {e.addr, e.phase, e.depth, e.ovf, e.unf}) begin
            errors++;
            $display("FAIL call_ret step %0d: got addr=%h ph=%b d=%0d ovf=%b unf=%b, expected addr=%h ph=%b d=%0d ovf=%b unf=%b",
                     i, addr, phase, depth, ovf, unf, e.addr, e.phase, e.depth, e.ovf, e.unf);
         end
      end
   endtask

   task automatic test_overflow_underflow();
      step_t s[11];
      exp_t  e;
      s[0]  = st(JMP,  'h000, 0, 'h000, 0, 0, 0);
      s[1]  = st(CALL, 'h010, 0, 'h010, 1, 0, 0);
      s[2]  = st(CALL, 'h020, 0, 'h020, 2, 0, 0);
      s[3]  = st(CALL, 'h030, 0, 'h030, 3, 0, 0);
      s[4]  = st(CALL, 'h040, 0, 'h040, 4, 0, 0);
      s[5]  = st(CALL, 'h050, 0, 'h050, 4, 1, 0);
      s[6]  = st(RET,  'h000, 0, 'h041, 3, 1, 0);
      s[7]  = st(RET,  'h000, 0, 'h031, 2, 1, 0);
      s[8]  = st(RET,  'h000, 0, 'h021, 1, 1, 0);
      s[9]  = st(RET,  'h000, 0, 'h011, 0, 1, 0);
      s[10] = st(RET,  'h000, 0, 'h012, 0, 1, 1);
      foreach (s[i]) begin
         do_pair(s[i]);
         e = sb.pop_front();
         checks++;
         if ({addr, phase, depth, ovf, unf} !== {e.addr, e.phase, e.depth, e.ovf, e.unf}) begin
            errors++;
            $display("FAIL ovf_unf step %0d: got addr=%h ph=%b d=%0d ovf=%b unf=%b, expected addr=%h ph=%b d=%0d ovf=%b unf=%b",
                     i, addr, phase, depth, ovf, unf, e.addr, e.phase, e.depth, e.ovf, e.unf);
         end
      end
   endtask

   task automatic test_err_clr();
      step_t s[8];
      exp_t  e;
      // Clear alone at a fetch-phase edge with run low: flags drop regardless of phase.
      run = 1'b0;
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++;
      if (ovf !== 1'b0 || unf !== 1'b0 || addr !== ADDR_W'('h012)) begin
         errors++;
         $display("FAIL err_clr_idle: got ovf=%b unf=%b addr=%h, expected ovf=0 unf=0 addr=012", ovf, unf, addr);
      end
      s[0] = st(JMP,  'h300, 0, 'h300, 0, 0, 0);
      s[1] = st(CALL, 'h310, 0, 'h310, 1, 0, 0);
      s[2] = st(CALL, 'h320, 0, 'h320, 2, 0, 0);
      s[3] = st(CALL, 'h330, 0, 'h330, 3, 0, 0);
      s[4] = st(CALL, 'h340, 0, 'h340, 4, 0, 0);
      s[5] = st(CALL, 'h350, 1, 'h350, 4, 1, 0);
      s[6] = st(HOLD, 'h000, 1, 'h350, 4, 0, 0);
      s[7] = st(RET,  'h000, 0, 'h341, 3, 0, 0);
      foreach (s[i]) begin
         do_pair(s[i]);
         e = sb.pop_front();
         checks++;
         if ({addr, phase, depth, ovf, unf} !== {e.addr, e.phase, e.depth, e.ovf, e.unf}) begin
            errors++;
            $display("FAIL err_clr step %0d: got addr=%h ph=%b d=%0d ovf=%b unf=%b, expected addr=%h ph=%b d=%0d ovf=%b unf=%b",
                     i, addr, phase, depth, ovf, unf, e.addr, e.phase, e.depth, e.ovf, e.unf);
         end
      end
   endtask

   task automatic test_run_freeze_and_reset();
      exp_t e;
      run = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         e.addr = 'h341; e.phase = 1'b0; e.depth = 3; e.ovf = 1'b0; e.unf = 1'b0;
         sb.push_back(e);
      end
      run = 1'b0;
      for (int i = 0; i < 3; i++) begin
         op = (i == 0) ? JMP : (i == 1) ? CALL : RET;
         target = ADDR_W'('h7A0 + i);
         tick();
         e = sb.pop_front();
         checks++;
         if ({addr, phase, depth} !== {e.addr, e.phase, e.depth}) begin
            errors++;
            $display("FAIL run_freeze cycle %0d: got addr=%h ph=%b d=%0d, expected addr=%h ph=%b d=%0d",
                     i, addr, phase, depth, e.addr, e.phase, e.depth);
         end
      end
      // Resume finishes the same pair exactly once.
      run = 1'b1;
      op = INC;
      tick();
      checks++;
      if ({addr, phase, depth} !== {ADDR_W'('h342), 1'b1, DEPTH_W'(3)}) begin
         errors++;
         $display("FAIL run_resume: got addr=%h ph=%b d=%0d, expected addr=342 ph=1 d=3", addr, phase, depth);
      end
      run = 1'b1;
      tick();
      reset = 1'b0;
      op = CALL;
      err_clr = 1'b0;
      tick();
      reset = 1'b1;
      op = INC;
      checks++;
      if ({addr, phase, depth, ovf, unf} !== {ADDR_W'(0), 1'b1, DEPTH_W'(0), 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL mid_reset: got addr=%h ph=%b d=%0d ovf=%b unf=%b, expected addr=000 ph=1 d=0 ovf=0 unf=0",
                  addr, phase, depth, ovf, unf);
      end
   endtask

   task automatic test_back_to_back();
      step_t s[4];
      exp_t  e;
      s[0] = st(RET,  'h000, 0, 'h001, 0, 0, 1);
      s[1] = st(HOLD, 'h000, 1, 'h001, 0, 0, 0);
      s[2] = st(RSVD, 'h000, 0, 'h002, 0, 0, 0);
      s[3] = st(CALL, 'hFFF, 0, 'hFFF, 1, 0, 0);
      foreach (s[i]) do_pair(s[i]);
      for (int i = 0; i < 4; i++) begin
         e = sb.pop_back();
         if (i == 0) begin
            checks++;
            if ({addr, phase, depth, ovf, unf} !== {e.addr, e.phase, e.depth, e.ovf, e.unf}) begin
               errors++;
               $display("FAIL back_to_back final: got addr=%h ph=%b d=%0d ovf=%b unf=%b, expected addr=%h ph=%b d=%0d ovf=%b unf=%b",
                        addr, phase, depth, ovf, unf, e.addr, e.phase, e.depth, e.ovf, e.unf);
            end
         end
      end
      do_pair(st(RET, 'h000, 0, 'h003, 0, 0, 0));
      e = sb.pop_front();
      checks++;
      if ({addr, phase, depth, ovf, unf} !== {e.addr, e.phase, e.depth, e.ovf, e.unf}) begin
         errors++;
         $display("FAIL back_to_back ret_wrap: got addr=%h ph=%b d=%0d ovf=%b unf=%b, expected addr=%h ph=%b d=%0d ovf=%b unf=%b",
                  addr, phase, depth, ovf, unf, e.addr, e.phase, e.depth, e.ovf, e.unf);
      end
   endtask

   initial begin
      test_reset();
      test_inc_phase();
      test_wrap_bra();
      test_call_ret();
      test_overflow_underflow();
      test_err_clr();
      test_run_freeze_and_reset();
      test_back_to_back();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
